// File: rtl/tmp_wb_if.sv
// Wishbone B4 pipelined bus bundle between a system master and the BRAM front-end slave.
// Signal names keep the slave's point of view (_i = into slave, _o = out of slave).
interface tmp_wb_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/tmp_wb_interface.sv
// Wishbone pipelined slave that turns one bus transaction at a time into single-cycle
// read/write strobes toward a 1-cycle-latency synchronous memory. All outputs registered.
module tmp_wb_interface (
    input  logic         clk_i,
    input  logic         rst_i,
    tmp_wb_if.slave      wb,
    output logic [31:0]  addr_o,
    output logic         read_o,
    input  logic [31:0]  read_data_i,
    output logic         write_o,
    output logic [31:0]  write_data_o,
    output logic [3:0]   sel_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        stall_q, stall_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        accept;

    assign accept = (state_q == StIdle) && wb.wb_cyc_i && wb.wb_stb_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq:  begin
                if (!wb.wb_cyc_i) state_d = StIdle;
                else              state_d = we_q ? StAck : StWait;
            end
            StWait: state_d = wb.wb_cyc_i ? StAck : StIdle;
            StAck:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are derived from the state being entered, so they line up
    // with that state in the following cycle.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        if (accept) begin
            we_d    = wb.wb_we_i;
            addr_d  = wb.wb_adr_i;
            wdata_d = wb.wb_dat_i;
            sel_d   = wb.wb_sel_i;
        end
        read_d  = accept && !wb.wb_we_i;
        write_d = accept && wb.wb_we_i;
        stall_d = (state_d != StIdle);
        ack_d   = (state_d == StAck);
        // Bus data is only non-zero alongside a read ack; writes ack with zero.
        dat_d   = ((state_q == StWait) && (state_d == StAck)) ? read_data_i : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            dat_q   <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            sel_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            stall_q <= stall_d;
            read_q  <= read_d;
            write_q <= write_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
        end
    end

    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_stall_o = stall_q;
    assign addr_o        = addr_q;
    assign read_o        = read_q;
    assign write_o       = write_q;
    assign write_data_o  = wdata_q;
    assign sel_o         = sel_q;

endmodule

// File: tb/tb_tmp_wb_interface.sv
// Bench for tmp_wb_interface: directed vector table, hand-written multi-cycle corner
// cases, then random transactions checked against a word-array reference memory.
module tb_tmp_wb_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic [31:0] addr_o, write_data_o, read_data_i;
    logic        read_o, write_o;
    logic [3:0]  sel_o;

    tmp_wb_if bus ();

    tmp_wb_interface dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb           (bus.slave),
        .addr_o       (addr_o),
        .read_o       (read_o),
        .read_data_i  (read_data_i),
        .write_o      (write_o),
        .write_data_o (write_data_o),
        .sel_o        (sel_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] bmask(logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Environment memory: byte-lane writes, 1-cycle registered read, lane-masked output.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            if (write_o)
                mem[addr_o[7:0]] <= (mem[addr_o[7:0]] & ~bmask(sel_o)) |
                                    (write_data_o & bmask(sel_o));
            if (read_o) rd_q <= mem[addr_o[7:0]];
        end
    end
    assign read_data_i = rd_q & bmask(sel_o);

    // Reference memory, updated only from the bench's view of completed transactions.
    logic [31:0] ref_mem [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        @(posedge clk);
        #1;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rd);
        logic got;
        got = 1'b0;
        drive_req(we, adr, dat, sel);
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("write_strobe", {31'h0, write_o}, {31'h0, we});
                chk("read_strobe", {31'h0, read_o}, {31'h0, !we});
                chk("addr_o", addr_o, adr);
                chk("sel_o", {28'h0, sel_o}, {28'h0, sel});
                chk("write_data_o", write_data_o, dat);
            end
            if (bus.wb_ack_o) begin
                got = 1'b1;
                chk("ack_latency", n, we ? 32'd2 : 32'd3);
                chk("ack_data", bus.wb_dat_o, we ? 32'h0 : exp_rd);
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        bus.wb_cyc_i = 1'b0;
        if (we)
            ref_mem[adr[7:0]] = (ref_mem[adr[7:0]] & ~bmask(sel)) | (dat & bmask(sel));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{we: 1'b1, adr: 32'h10, dat: 32'hDEADBEEF, sel: 4'hF, exp: 32'h0};
        vecs[1] = '{we: 1'b0, adr: 32'h10, dat: 32'h0,        sel: 4'hF, exp: 32'hDEADBEEF};
        vecs[2] = '{we: 1'b0, adr: 32'h10, dat: 32'h0,        sel: 4'h3, exp: 32'h0000BEEF};
        vecs[3] = '{we: 1'b1, adr: 32'h10, dat: 32'h00AA0000, sel: 4'h4, exp: 32'h0};
        vecs[4] = '{we: 1'b0, adr: 32'h10, dat: 32'h0,        sel: 4'hF, exp: 32'hDEAABEEF};
        vecs[5] = '{we: 1'b0, adr: 32'h10, dat: 32'h0,        sel: 4'h0, exp: 32'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk("rst_stall", {31'h0, bus.wb_stall_o}, 32'h0);
        chk("rst_strobes", {30'h0, read_o, write_o}, 32'h0);
        chk("rst_dat_o", bus.wb_dat_o, 32'h0);
        chk("rst_addr_o", addr_o, 32'h0);
        chk("rst_wdata", write_data_o, 32'h0);
        chk("rst_sel", {28'h0, sel_o}, 32'h0);
        rst = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < 6; i++)
            txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp);

        // Back-to-back: stb held across the first read; second accepted after its ack.
        drive_req(1'b0, 32'h10, 32'h0, 4'hF);
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 32'h11;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("b2b_stall", {31'h0, bus.wb_stall_o}, 32'h1);
        end
        chk("b2b_first_ack", {31'h0, bus.wb_ack_o}, 32'h1);
        @(negedge clk);
        chk("b2b_idle_stall", {31'h0, bus.wb_stall_o}, 32'h0);
        @(negedge clk);
        bus.wb_stb_i = 1'b0;
        chk("b2b_second_read", {31'h0, read_o}, 32'h1);
        chk("b2b_second_addr", addr_o, 32'h11);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_second_ack", {31'h0, bus.wb_ack_o}, 32'h1);
        chk("b2b_second_data", bus.wb_dat_o, ref_mem[8'h11]);
        bus.wb_cyc_i = 1'b0;

        // Abort: drop cyc while waiting on read data.
        drive_req(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("abort_wait_stall", {31'h0, bus.wb_stall_o}, 32'h1);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);
        chk("abort_no_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk("abort_stall", {31'h0, bus.wb_stall_o}, 32'h0);
        chk("abort_dat", bus.wb_dat_o, 32'h0);
        @(negedge clk);
        chk("abort_no_late_ack", {31'h0, bus.wb_ack_o}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [31:0] adr, dat;
            logic [3:0]  sel;
            we  = 1'($urandom_range(0, 1));
            adr = 32'($urandom_range(0, 15));
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            txn(we, adr, dat, sel, ref_mem[adr[7:0]] & bmask(sel));
        end

        // Reset during a read's request cycle clears everything with no ack.
        drive_req(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        chk("rst_mid_read_req", {31'h0, read_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk("rst_mid_stall", {31'h0, bus.wb_stall_o}, 32'h0);
        chk("rst_mid_strobes", {30'h0, read_o, write_o}, 32'h0);
        chk("rst_mid_addr", addr_o, 32'h0);
        chk("rst_mid_sel", {28'h0, sel_o}, 32'h0);
        chk("rst_mid_wdata", write_data_o, 32'h0);
        chk("rst_mid_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_no_ack", {31'h0, bus.wb_ack_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
